// File: rtl/pattern_tx.sv
// Serial frame transmitter: 5-bit sync pattern, DATA_W payload bits MSB-first,
// then an even-parity bit. Frames may run back-to-back when start meets done.
module pattern_tx #(
  parameter logic [4:0] PATTERN = 5'b01101,
  parameter int         DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              dout
);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, PAR} state_t;

  state_t            state_reg, state_next;
  logic [4:0]        cnt_reg, cnt_next;
  logic [DATA_W-1:0] shreg_reg, shreg_next;
  logic              par_reg, par_next;
  logic              dout_reg, dout_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              accept;
  logic [2:0]        pat_idx;

  assign ready   = !busy_reg | done_reg;
  assign accept  = start & ready;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign dout    = dout_reg;
  assign pat_idx = cnt_reg[2:0] - 3'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shreg_reg <= '0;
      par_reg   <= 1'b0;
      dout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shreg_reg <= shreg_next;
      par_reg   <= par_next;
      dout_reg  <= dout_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // Outputs are registered, so each branch computes the bit shown next cycle;
  // state_reg always names the field currently on dout.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shreg_next = shreg_reg;
    par_next   = par_reg;
    dout_next  = 1'b0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      IDLE, PAR: begin
        if (accept) begin
          state_next = SYNC;
          cnt_next   = 5'd4;
          shreg_next = data;
          par_next   = 1'b0;
          dout_next  = PATTERN[4];
          busy_next  = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      SYNC: begin
        busy_next = 1'b1;
        if (cnt_reg == 5'd0) begin
          state_next = DATA;
          cnt_next   = 5'(DATA_W - 1);
          dout_next  = shreg_reg[DATA_W-1];
          shreg_next = shreg_reg << 1;
          par_next   = par_reg ^ shreg_reg[DATA_W-1];
        end else begin
          cnt_next  = cnt_reg - 5'd1;
          dout_next = PATTERN[pat_idx];
        end
      end
      DATA: begin
        busy_next = 1'b1;
        if (cnt_reg == 5'd0) begin
          // par_reg already holds every payload bit sent so far
          state_next = PAR;
          dout_next  = par_reg;
          done_next  = 1'b1;
        end else begin
          cnt_next   = cnt_reg - 5'd1;
          dout_next  = shreg_reg[DATA_W-1];
          shreg_next = shreg_reg << 1;
          par_next   = par_reg ^ shreg_reg[DATA_W-1];
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pattern_tx.sv
// Scoreboard bench for pattern_tx: every accepted frame pushes its expected
// per-cycle {dout,busy,done}; a negedge monitor pops and compares.
module tb_pattern_tx;

  localparam logic [4:0] PAT = 5'b01101;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, busy, done, dout;

  int n_checks = 0;
  int n_fail   = 0;
  int n_frames = 0;
  int hits_obs = 0;
  int hits_exp = 0;

  logic [2:0] exp_q[$];
  logic [2:0] cur_exp;
  logic       model_ready = 1'b1;
  logic [4:0] win_obs = '0;
  logic [4:0] win_exp = '0;
  logic [13:0] cap;

  pattern_tx #(.PATTERN(PAT), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .data  (data),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] d);
    for (int i = 4; i >= 0; i--) exp_q.push_back({PAT[i], 1'b1, 1'b0});
    for (int i = 7; i >= 0; i--) exp_q.push_back({d[i], 1'b1, 1'b0});
    exp_q.push_back({^d, 1'b1, 1'b1});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Acceptance model: start counts only when the model says the link is ready.
  always @(posedge clk) begin
    if (reset && start && model_ready) begin
      push_frame(data);
      n_frames++;
      $display("frame %0d accepted data=%02h", n_frames, data);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      cur_exp = 3'b000;
      win_obs = '0;
      win_exp = '0;
    end else if (exp_q.size() > 0) begin
      cur_exp = exp_q.pop_front();
    end else begin
      cur_exp = 3'b000;
    end
    check_val("dout", dout, cur_exp[2]);
    check_val("busy", busy, cur_exp[1]);
    check_val("done", done, cur_exp[0]);
    model_ready = (exp_q.size() == 0);
    check_val("ready", ready, model_ready);
    if (reset) begin
      win_obs = {win_obs[3:0], dout};
      win_exp = {win_exp[3:0], cur_exp[2]};
      if (win_obs == PAT) hits_obs++;
      if (win_exp == PAT) hits_exp++;
      check_val("detect", win_obs == PAT, win_exp == PAT);
    end
  end

  initial begin
    // Reset and idle
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) tick();

    // Single frame A5 with an explicit captured stream
    start = 1'b1; data = 8'hA5;
    tick();
    start = 1'b0; data = 8'h00;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      #1 cap = {cap[12:0], dout};
    end
    check_val("a5_stream", cap, 14'b01101_10100101_0);
    repeat (4) tick();

    // Back-to-back: 01 then FF accepted in the done cycle
    start = 1'b1; data = 8'h01;
    tick();
    data = 8'hFF;
    repeat (14) tick();
    start = 1'b0; data = 8'h00;
    repeat (18) tick();

    // Start pulse during a frame must be ignored
    start = 1'b1; data = 8'h3C;
    tick();
    start = 1'b0;
    repeat (2) tick();
    start = 1'b1; data = 8'h00;
    tick();
    start = 1'b0;
    repeat (20) tick();

    // Asynchronous reset in the middle of a frame
    start = 1'b1; data = 8'hC3;
    tick();
    start = 1'b0;
    repeat (8) tick();
    #2 reset = 1'b0;
    #1;
    check_val("rst_dout", dout, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    start = 1'b1; data = 8'h5A;
    tick();
    start = 1'b0;
    repeat (18) tick();

    // Loopback train: 20 random payloads plus one carrying 01101
    hits_obs = 0;
    hits_exp = 0;
    start = 1'b1;
    for (int k = 0; k < 21; k++) begin
      data = (k == 20) ? 8'h6D : 8'($urandom_range(0, 255));
      tick();
      repeat (13) tick();
    end
    start = 1'b0;
    repeat (20) tick();
    check_val("detect_hits", hits_obs, hits_exp);
    check_val("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_tx.md
# pattern_tx

Serial frame transmitter that drives the 1-bit stream consumed by the `detect` pattern detector. On a start request it emits a fixed 5-bit sync pattern, then a parallel data word MSB-first, then an even-parity bit. It sits on the transmit side of the serial link, and its `dout` connects directly to the detector's `din` in loopback benches.

## Interface
- `PATTERN`, default 5'b01101: sync pattern, sent MSB (bit 4) first.
- `DATA_W`, default 8: payload width in bits; legal range 1..16.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low reset. Asserting it (0) clears state immediately; deassertion is synchronous to `clk` at the board level.
- `start`  in  1: frame request, sampled on the rising edge when `ready`=1.
- `data`  in  DATA_W: payload, captured in the same cycle `start` is accepted.
- `ready`  out  1: combinational, equal to `!busy | done`.
- `busy`  out  1: registered; high while a frame bit is on `dout`.
- `done`  out  1: registered; high for exactly the cycle the parity bit is on `dout`.
- `dout`  out  1: registered serial output.

## Operation
- The FSM has four states: IDLE, SYNC, DATA, PAR.
- A 5-bit bit counter and a DATA_W-bit shift register hold the captured payload.
- A running parity register accumulates the XOR of the data bits as they are sent.
- IDLE: `dout`=0, `busy`=0, `done`=0. On `start`=1, go to SYNC: capture `data`, load counter = 4, clear parity.
- SYNC: `dout`=PATTERN[counter]. Decrement the counter each cycle. After the bit-0 cycle, go to DATA with counter = DATA_W-1.
- DATA: `dout`=shreg MSB, then shift left and XOR the sent bit into parity. After DATA_W bits, go to PAR.
- PAR: `dout` = XOR of all payload bits, so the total count of 1s in payload plus parity is even. `done`=1.
  - If `start`=1 in this cycle, go to SYNC and capture the new `data`. Frames are back-to-back with no idle gap.
  - Otherwise go to IDLE.
- `start` is ignored whenever `ready`=0. `data` is only read in the accept cycle, so the source may change it freely afterward.
- Reset values: state=IDLE, `dout`=0, `busy`=0, `done`=0, counter=0, shreg=0, parity=0.
- Reset asserted mid-frame aborts the frame immediately: `dout` goes to 0 asynchronously and no `done` is generated.
- The first accept after reset deassertion is on the first rising edge where `reset`=1 and `start`=1.
- With `start` held high permanently, the block emits a continuous frame train. Every frame is exactly 5+DATA_W+1 cycles long.

## Timing
- `start` accepted at edge T: the first sync bit appears on `dout` after edge T (cycle T+1), and `busy` rises in the same cycle.
- Cycle assignment for a frame accepted at T:
  - Sync bits: cycles T+1..T+5.
  - Data bits: cycles T+6..T+5+DATA_W.
  - Parity bit: cycle T+6+DATA_W, with `done`=1.
- With the default DATA_W=8, the parity bit is at T+14.
- `busy` falls after the parity cycle unless a new start is accepted in that cycle; in that case it stays high and the next sync bit is at T+15.
- Latency from `start` to the first `dout` bit is 1 cycle; throughput is one frame per 5+DATA_W+1 cycles.
- Connected to `detect` (which registers its input), the detector flags the sync pattern a fixed number of cycles after the last sync bit, as set by its registration depth. The loopback test checks this offset once and holds it constant.

## Test plan
- Reset, idle: hold `reset`=0 for 3 cycles, then release with `start`=0 for 10 cycles. Required: `dout`=0, `busy`=0, `done`=0, `ready`=1 throughout.
- Single frame: `start`=1 with `data`=8'hA5 for 1 cycle. Required:
  - `dout` over cycles T+1..T+14 = 0,1,1,0,1, 1,0,1,0,0,1,0,1, 0.
  - `done` high only at T+14; `busy` high for T+1..T+14.
- Back-to-back: `start` held high with `data`=8'h01 for the first accept, then 8'hFF accepted during the `done` cycle. Required:
  - Second frame sync starts at T+15 with no gap.
  - Payload 1,1,1,1,1,1,1,1, parity 0.
  - First frame's parity bit is 1.
- Ignored start: pulse `start` with `data`=8'h00 at T+3 during a frame. Required: the in-flight frame is unchanged and no extra frame follows.
- Mid-frame reset: assert `reset`=0 at T+8 (asynchronously, between edges). Required:
  - `dout`/`busy` drop to 0 immediately, with no `done`.
  - After release, a new `start` produces a clean full frame.
- Loopback: connect `dout` to `detect.din`, send 20 random payloads plus a payload containing 01101. Required:
  - Detect fires once per frame at the fixed sync offset.
  - Any additional detect pulse falls only where the 01101 pattern genuinely appears inside the payload, at the bit position predicted by a reference model.
